r_type_seq_cu: RTL and testbench

- Multi-cycle sequencer for the R-type register datapath (regfile, ALU, shift accumulator, PC).
- Accepts one 32-bit instruction per valid/ready handshake and decodes opcode/fn_code.
- Drives ALU control plus load, step and writeback strobes through FETCH, DECODE, EXEC, SHIFT and WB phases.
- Shifts run iteratively, one bit per cycle, so the ALU needs no barrel shifter.

---
 rtl/r_type_seq_cu_if.sv | 28 ++
 rtl/r_type_seq_cu.sv | 204 ++++++++++++++++++++
 tb/tb_r_type_seq_cu.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/r_type_seq_cu_if.sv
// Handshake and control bus between the R-type sequencer and its datapath.
// master: instruction source / datapath side; slave: the sequencer.
interface r_type_seq_cu_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        ir_load;
    logic        acc_load;
    logic        shift_step;
    logic [3:0]  alu_control;
    logic        RegWrite;
    logic        ALUtoReg;
    logic        pc_inc;
    logic        illegal;
    logic        busy;

    modport master (
        output instr_valid, instr,
        input  instr_ready, ir_load, acc_load, shift_step, alu_control,
               RegWrite, ALUtoReg, pc_inc, illegal, busy
    );

    modport slave (
        input  instr_valid, instr,
        output instr_ready, ir_load, acc_load, shift_step, alu_control,
               RegWrite, ALUtoReg, pc_inc, illegal, busy
    );
endinterface

// File: rtl/r_type_seq_cu.sv
// Multi-cycle R-type sequencer: FETCH -> DECODE -> EXEC -> [SHIFT] -> WB.
// Shifts are done one bit per cycle via shift_step pulses.
// Optional macro RSEQ_RETIRE_CNT_EN adds retired/illegal instruction counters.
module r_type_seq_cu #(
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    r_type_seq_cu_if.slave   bus
`ifdef RSEQ_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] illegal_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_SHIFT,
        S_WB
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    state_t             state_q, state_d;
    logic [5:0]         opcode_q, opcode_d;
    logic [5:0]         fn_q, fn_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         alu_q, alu_d;

    logic               legal;
    logic               is_shift;
    logic [3:0]         dec_op;

    logic               instr_ready, ir_load, acc_load, shift_step;
    logic               reg_write, alu_to_reg, pc_inc, illegal, busy;
    logic [3:0]         alu_control;

    // Register fields, rs/rt/rd are consumed by the datapath, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instr[25:11];

    // Decode the latched opcode/fn_code into legality and ALU operation.
    always_comb begin
        legal    = 1'b0;
        is_shift = 1'b0;
        dec_op   = ALU_AND;
        if (opcode_q == 6'b000000) begin
            case (fn_q)
                6'b100000: begin legal = 1'b1; dec_op = ALU_ADD; end
                6'b100010: begin legal = 1'b1; dec_op = ALU_SUB; end
                6'b100100: begin legal = 1'b1; dec_op = ALU_AND; end
                6'b100101: begin legal = 1'b1; dec_op = ALU_OR;  end
                6'b000000: begin legal = 1'b1; dec_op = ALU_SLL; is_shift = 1'b1; end
                6'b000010: begin legal = 1'b1; dec_op = ALU_SRL; is_shift = 1'b1; end
                default:   begin legal = 1'b0; end
            endcase
        end
    end

    // Next-state and output logic; reset forces every output low in its cycle.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        fn_d        = fn_q;
        shamt_d     = shamt_q;
        cnt_d       = cnt_q;
        alu_d       = alu_q;
        instr_ready = 1'b0;
        ir_load     = 1'b0;
        acc_load    = 1'b0;
        shift_step  = 1'b0;
        reg_write   = 1'b0;
        alu_to_reg  = 1'b0;
        pc_inc      = 1'b0;
        illegal     = 1'b0;
        alu_control = alu_q;
        busy        = (state_q != S_FETCH);

        case (state_q)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    ir_load  = 1'b1;
                    opcode_d = bus.instr[31:26];
                    fn_d     = bus.instr[5:0];
                    shamt_d  = bus.instr[6 +: SHAMT_W];
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_control = dec_op;
                alu_d       = dec_op;
                if (is_shift) begin
                    acc_load = 1'b1;
                    cnt_d    = shamt_q;
                    // A zero shift skips SHIFT so the counter never wraps.
                    state_d  = (shamt_q == '0) ? S_WB : S_SHIFT;
                end else begin
                    state_d = S_WB;
                end
            end
            S_SHIFT: begin
                shift_step = 1'b1;
                cnt_d      = cnt_q - 1'b1;
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                alu_to_reg = 1'b1;
                pc_inc     = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (reset) begin
            instr_ready = 1'b0;
            ir_load     = 1'b0;
            acc_load    = 1'b0;
            shift_step  = 1'b0;
            reg_write   = 1'b0;
            alu_to_reg  = 1'b0;
            pc_inc      = 1'b0;
            illegal     = 1'b0;
            busy        = 1'b0;
            alu_control = '0;
        end
    end

    // State, latched instruction fields, shift counter and held ALU op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            fn_q     <= '0;
            shamt_q  <= '0;
            cnt_q    <= '0;
            alu_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            fn_q     <= fn_d;
            shamt_q  <= shamt_d;
            cnt_q    <= cnt_d;
            alu_q    <= alu_d;
        end
    end

`ifdef RSEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q, illegal_cnt_q;

    // Retired-instruction and illegal-instruction counters, wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q     <= '0;
            illegal_cnt_q <= '0;
        end else begin
            if (reg_write) retired_q     <= retired_q + 1'b1;
            if (illegal)   illegal_cnt_q <= illegal_cnt_q + 1'b1;
        end
    end

    assign retired_cnt = retired_q;
    assign illegal_cnt = illegal_cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

    assign bus.instr_ready = instr_ready;
    assign bus.ir_load     = ir_load;
    assign bus.acc_load    = acc_load;
    assign bus.shift_step  = shift_step;
    assign bus.alu_control = alu_control;
    assign bus.RegWrite    = reg_write;
    assign bus.ALUtoReg    = alu_to_reg;
    assign bus.pc_inc      = pc_inc;
    assign bus.illegal     = illegal;
    assign bus.busy        = busy;

endmodule

// File: tb/tb_r_type_seq_cu.sv
// Directed self-checking bench for r_type_seq_cu.
// Counter checks are compiled in when RSEQ_RETIRE_CNT_EN is defined.
module tb_r_type_seq_cu;

    logic clk;
    logic reset;
    int   checks;
    int   fails;
    logic [3:0] alu_model;

    r_type_seq_cu_if bus ();

`ifdef RSEQ_RETIRE_CNT_EN
    logic [31:0] retired_cnt, illegal_cnt;
`endif

    r_type_seq_cu #(.SHAMT_W(5), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef RSEQ_RETIRE_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {instr_ready, ir_load, acc_load, shift_step, RegWrite, ALUtoReg, pc_inc, illegal, busy, alu_control}
    logic [12:0] obs;
    assign obs = {bus.instr_ready, bus.ir_load, bus.acc_load, bus.shift_step, bus.RegWrite,
                  bus.ALUtoReg, bus.pc_inc, bus.illegal, bus.busy, bus.alu_control};

    function automatic logic [12:0] ev(bit rdy, bit irl, bit acc, bit step, bit rw,
                                       bit a2r, bit pc, bit ill, bit bsy, logic [3:0] alu);
        return {rdy, irl, acc, step, rw, a2r, pc, ill, bsy, alu};
    endfunction

    function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] sh, logic [5:0] fn);
        return {op, 5'd1, 5'd2, 5'd3, sh, fn};
    endfunction

    // Expected outputs for cycle cyc of a legal instruction (cycle 0 = handshake).
    function automatic logic [12:0] seq_exp(int cyc, logic [3:0] op, logic [3:0] prev,
                                            int shamt, bit sh);
        int wb;
        wb = 3 + (sh ? shamt : 0);
        if (cyc == 0)  return ev(1, 1, 0, 0, 0, 0, 0, 0, 0, prev);
        if (cyc == 1)  return ev(0, 0, 0, 0, 0, 0, 0, 0, 1, prev);
        if (cyc == 2)  return ev(0, 0, sh, 0, 0, 0, 0, 0, 1, op);
        if (cyc == wb) return ev(0, 0, 0, 0, 1, 1, 1, 0, 1, op);
        return ev(0, 0, 0, 1, 0, 0, 0, 0, 1, op);
    endfunction

    task automatic begin_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        begin_cycle();
        @(negedge clk);
        checks++;
        if (obs !== 13'b0) begin
            $display("FAIL reset_cycle: got %b expected %b", obs, 13'b0);
            fails++;
        end
        for (int i = 0; i < 5; i++) begin
            begin_cycle();
            reset = 1'b0;
            @(negedge clk);
            checks++;
            if (obs !== ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000)) begin
                $display("FAIL idle_%0d: got %b expected %b", i, obs,
                         ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
                fails++;
            end
        end
        alu_model = 4'b0000;
    endtask

    task automatic test_add();
        logic [12:0] e;
        for (int c = 0; c < 5; c++) begin
            begin_cycle();
            if (c == 0) begin
                bus.instr_valid = 1'b1;
                bus.instr = mk(6'b000000, 5'd0, 6'b100000);
            end
            if (c == 4) bus.instr_valid = 1'b0;
            @(negedge clk);
            e = (c == 4) ? ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010)
                         : seq_exp(c, 4'b0010, alu_model, 0, 0);
            checks++;
            if (obs !== e) begin
                $display("FAIL add_cyc%0d: got %b expected %b", c, obs, e);
                fails++;
            end
        end
        alu_model = 4'b0010;
    endtask

    task automatic test_back_to_back();
        logic [5:0]  fns [3];
        logic [3:0]  ops [3];
        logic [12:0] e;
        fns = '{6'b100010, 6'b100100, 6'b100101};
        ops = '{4'b0110, 4'b0000, 4'b0001};
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 4; c++) begin
                begin_cycle();
                if (c == 0) begin
                    bus.instr_valid = 1'b1;
                    bus.instr = mk(6'b000000, 5'd0, fns[i]);
                end
                @(negedge clk);
                e = seq_exp(c, ops[i], alu_model, 0, 0);
                checks++;
                if (obs !== e) begin
                    $display("FAIL b2b_%0d_cyc%0d: got %b expected %b", i, c, obs, e);
                    fails++;
                end
            end
            alu_model = ops[i];
        end
    endtask

    task automatic test_shift();
        logic [12:0] e;
        // SLL by 3
        for (int c = 0; c < 7; c++) begin
            begin_cycle();
            if (c == 0) begin
                bus.instr_valid = 1'b1;
                bus.instr = mk(6'b000000, 5'd3, 6'b000000);
            end
            @(negedge clk);
            e = seq_exp(c, 4'b0011, alu_model, 3, 1);
            checks++;
            if (obs !== e) begin
                $display("FAIL sll3_cyc%0d: got %b expected %b", c, obs, e);
                fails++;
            end
        end
        alu_model = 4'b0011;
        // SRL by 0: no SHIFT cycles
        for (int c = 0; c < 4; c++) begin
            begin_cycle();
            if (c == 0) bus.instr = mk(6'b000000, 5'd0, 6'b000010);
            @(negedge clk);
            e = seq_exp(c, 4'b0100, alu_model, 0, 1);
            checks++;
            if (obs !== e) begin
                $display("FAIL srl0_cyc%0d: got %b expected %b", c, obs, e);
                fails++;
            end
        end
        alu_model = 4'b0100;
    endtask

    task automatic test_illegal();
        logic [31:0] words [2];
        logic [12:0] e;
        words = '{mk(6'b111111, 5'd0, 6'b000000), mk(6'b000000, 5'd0, 6'b000001)};
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 3; c++) begin
                begin_cycle();
                if (c == 0) begin
                    bus.instr_valid = 1'b1;
                    bus.instr = words[i];
                end
                if (c == 2) bus.instr_valid = 1'b0;
                @(negedge clk);
                case (c)
                    0:       e = ev(1, 1, 0, 0, 0, 0, 0, 0, 0, alu_model);
                    1:       e = ev(0, 0, 0, 0, 0, 0, 1, 1, 1, alu_model);
                    default: e = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, alu_model);
                endcase
                checks++;
                if (obs !== e) begin
                    $display("FAIL illegal_%0d_cyc%0d: got %b expected %b", i, c, obs, e);
                    fails++;
                end
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [12:0] e;
        // SLL by 31, reset lands on the 10th step (cycle 12)
        for (int c = 0; c < 14; c++) begin
            begin_cycle();
            if (c == 0) begin
                bus.instr_valid = 1'b1;
                bus.instr = mk(6'b000000, 5'd31, 6'b000000);
            end
            if (c == 12) begin
                reset = 1'b1;
                bus.instr_valid = 1'b0;
            end
            if (c == 13) reset = 1'b0;
            @(negedge clk);
            if (c == 12)      e = 13'b0;
            else if (c == 13) e = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
            else              e = seq_exp(c, 4'b0011, alu_model, 31, 1);
            checks++;
            if (obs !== e) begin
                $display("FAIL midreset_cyc%0d: got %b expected %b", c, obs, e);
                fails++;
            end
        end
        alu_model = 4'b0000;
`ifdef RSEQ_RETIRE_CNT_EN
        checks++;
        if (retired_cnt !== 32'd0 || illegal_cnt !== 32'd0) begin
            $display("FAIL cnt_after_reset: got %0d/%0d expected 0/0", retired_cnt, illegal_cnt);
            fails++;
        end
`endif
        // Next instruction (ADD) completes normally
        for (int c = 0; c < 5; c++) begin
            begin_cycle();
            if (c == 0) begin
                bus.instr_valid = 1'b1;
                bus.instr = mk(6'b000000, 5'd0, 6'b100000);
            end
            if (c == 4) bus.instr_valid = 1'b0;
            @(negedge clk);
            e = (c == 4) ? ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010)
                         : seq_exp(c, 4'b0010, alu_model, 0, 0);
            checks++;
            if (obs !== e) begin
                $display("FAIL post_reset_add_cyc%0d: got %b expected %b", c, obs, e);
                fails++;
            end
        end
        alu_model = 4'b0010;
`ifdef RSEQ_RETIRE_CNT_EN
        checks++;
        if (retired_cnt !== 32'd1) begin
            $display("FAIL retired_after_wb: got %0d expected 1", retired_cnt);
            fails++;
        end
`endif
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        alu_model = 4'b0000;
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        test_reset();
        test_add();
        test_back_to_back();
        test_shift();
        test_illegal();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
